// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcode, flag and arbiter FSM types
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_XOR   = 3'd4,
    ALU_NOR   = 3'd5,
    ALU_PASSB = 3'd6,
    ALU_SLT   = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  localparam int REQ_ID_W = $clog2(4);

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response bundle between requesters and alu_arbiter
interface alu_arbiter_if #(
  parameter int N    = 32,
  parameter int NREQ = 2
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0][2:0]   req_opcode;
  logic [NREQ-1:0][N-1:0] req_a;
  logic [NREQ-1:0][N-1:0] req_b;
  logic [NREQ-1:0]        req_setflags;
  logic [NREQ-1:0]        rsp_valid;
  logic [NREQ-1:0]        rsp_ready;
  logic [N-1:0]           rsp_result;
  logic [3:0]             rsp_flags;

  modport master (
    output req_valid, req_opcode, req_a, req_b, req_setflags, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags
  );

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, req_setflags, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags
  );
endinterface

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU; carry/overflow meaningful for ADD/SUB only
module alu
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  alu_op_e      op_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] result_o,
  output logic         carry_o,
  output logic         overflow_o
);
  logic         sub;
  logic [N-1:0] bx;
  logic [N:0]   sum;

  // SUB is a + ~b + 1, so carry means "no borrow"
  always_comb begin
    sub        = (op_i == ALU_SUB);
    bx         = sub ? ~b_i : b_i;
    sum        = {1'b0, a_i} + {1'b0, bx} + {{N{1'b0}}, sub};
    result_o   = '0;
    carry_o    = 1'b0;
    overflow_o = 1'b0;
    case (op_i)
      ALU_ADD, ALU_SUB: begin
        result_o   = sum[N-1:0];
        carry_o    = sum[N];
        overflow_o = (a_i[N-1] == bx[N-1]) && (sum[N-1] != a_i[N-1]);
      end
      ALU_AND:   result_o = a_i & b_i;
      ALU_OR:    result_o = a_i | b_i;
      ALU_XOR:   result_o = a_i ^ b_i;
      ALU_NOR:   result_o = ~(a_i | b_i);
      ALU_PASSB: result_o = b_i;
      ALU_SLT:   result_o = {{(N-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      default:   result_o = '0;
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one alu among NREQ requesters
// Optional architectural flag register: ALU_ARB_FLAG_REG_EN
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N    = 32,
  parameter int NREQ = 2
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
`ifdef ALU_ARB_FLAG_REG_EN
  ,
  output logic [3:0]   flags_q
`endif
);
  arb_state_e          state_q;
  logic [REQ_ID_W-1:0] rr_q;
  logic [NREQ-1:0]     owner_q;
  alu_op_e             op_q;
  logic [N-1:0]        a_q, b_q, res_q;
  alu_flags_t          flg_q;
  logic [NREQ-1:0]     rsp_valid_q;

  logic [NREQ-1:0]     grant;
  logic [REQ_ID_W-1:0] grant_id;
  logic                grant_any;
  logic [REQ_ID_W-1:0] rr_d;
  alu_op_e             op_d;
  logic [N-1:0]        a_d, b_d;
  logic                accept;

  logic [N-1:0]        alu_res;
  logic                alu_c, alu_v;
  alu_flags_t          new_flags;

  // First valid requester at or after rr_q, wrapping modulo NREQ
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!grant_any && (j == (int'(rr_q) + i) % NREQ) && bus.req_valid[j]) begin
          grant_any = 1'b1;
          grant[j]  = 1'b1;
          grant_id  = REQ_ID_W'(j);
        end
      end
    end
    rr_d = (grant_id == REQ_ID_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;
  end

  always_comb begin
    op_d = ALU_ADD;
    a_d  = '0;
    b_d  = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (grant[j]) begin
        op_d = alu_op_e'(bus.req_opcode[j]);
        a_d  = bus.req_a[j];
        b_d  = bus.req_b[j];
      end
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE && !reset) ? grant : '0;
  assign accept        = |bus.req_ready;

  alu #(.N(N)) u_alu (
    .op_i      (op_q),
    .a_i       (a_q),
    .b_i       (b_q),
    .result_o  (alu_res),
    .carry_o   (alu_c),
    .overflow_o(alu_v)
  );

  assign new_flags = '{n: alu_res[N-1], z: (alu_res == '0), c: alu_c, v: alu_v};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_q        <= '0;
      owner_q     <= '0;
      op_q        <= ALU_ADD;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      flg_q       <= '0;
      rsp_valid_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            owner_q <= grant;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rr_q    <= rr_d;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_q       <= alu_res;
          flg_q       <= new_flags;
          rsp_valid_q <= owner_q;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          // Only the owner's rsp_ready matters; rsp_valid_q is one-hot on it
          if (|(bus.rsp_ready & rsp_valid_q)) begin
            rsp_valid_q <= '0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_flags  = flg_q;

`ifdef ALU_ARB_FLAG_REG_EN
  logic setf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      setf_q  <= 1'b0;
      flags_q <= '0;
    end else begin
      if (state_q == ST_IDLE && accept) setf_q <= |(grant & bus.req_setflags);
      if (state_q == ST_EXEC && setf_q) flags_q <= new_flags;
    end
  end
`else
  logic unused_setflags;
  assign unused_setflags = ^bus.req_setflags;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter (vectors, sequences, random)
module tb_alu_arbiter;
  localparam int N    = 32;
  localparam int NREQ = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
`ifdef ALU_ARB_FLAG_REG_EN
  logic [3:0] flags_q;
`endif

  alu_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();

  alu_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus)
`ifdef ALU_ARB_FLAG_REG_EN
    ,
    .flags_q(flags_q)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    int          op;
    logic [31:0] a;
    logic [31:0] b;
    logic        sf;
    logic [31:0] res;
    logic [3:0]  flg;
  } vec_t;

  vec_t        vecs[12];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          m_rr = 0;
  logic [3:0]  m_flags = 4'h0;
  int          r_op[NREQ];
  logic [31:0] r_a[NREQ];
  logic [31:0] r_b[NREQ];
  logic        r_sf[NREQ];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference ALU from the opcode definitions: {result, N, Z, C, V}
  function automatic logic [35:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] w;
    logic [31:0] r;
    logic        c, v;
    c = 1'b0;
    v = 1'b0;
    r = 32'h0;
    case (op)
      0: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[31:0];
        c = w[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      1: begin
        r = a - b;
        c = (a >= b);
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = ~(a | b);
      6: r = b;
      7: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = 32'h0;
    endcase
    return {r, r[31], (r == 32'h0), c, v};
  endfunction

  task automatic set_req(input int id, input int op, input logic [31:0] a, input logic [31:0] b, input logic sf);
    r_op[id] = op;
    r_a[id]  = a;
    r_b[id]  = b;
    r_sf[id] = sf;
    bus.req_opcode[id]   = op[2:0];
    bus.req_a[id]        = a;
    bus.req_b[id]        = b;
    bus.req_setflags[id] = sf;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid = '1;
    bus.rsp_ready = '0;
    @(negedge clk);
    check("reset_req_ready", bus.req_ready, 0);
    check("reset_rsp_valid", bus.rsp_valid, 0);
    check("reset_rsp_result", bus.rsp_result, 0);
    check("reset_rsp_flags", bus.rsp_flags, 0);
`ifdef ALU_ARB_FLAG_REG_EN
    check("reset_flags_q", flags_q, 0);
`endif
    reset = 1'b0;
    bus.req_valid = '0;
    m_rr = 0;
    m_flags = 4'h0;
  endtask

  // Called at a negedge in IDLE; returns at a negedge in IDLE
  task automatic do_txn(input logic [NREQ-1:0] vmask, input int exp_id, input logic [31:0] exp_res,
                        input logic [3:0] exp_flg, input logic exp_sf, input int bp);
    logic [NREQ-1:0] oh;
    oh = NREQ'(1 << exp_id);
    bus.rsp_ready = '0;
    bus.req_valid = vmask;
    #1;
    check("grant", bus.req_ready, oh);
    @(posedge clk);
    m_rr = (exp_id + 1) % NREQ;
    @(negedge clk);
    bus.req_valid = '0;
    check("exec_no_rsp", bus.rsp_valid, 0);
    @(negedge clk);
    check("rsp_valid_latency", bus.rsp_valid, oh);
    check("rsp_result", bus.rsp_result, exp_res);
    check("rsp_flags", bus.rsp_flags, exp_flg);
    if (exp_sf) m_flags = exp_flg;
`ifdef ALU_ARB_FLAG_REG_EN
    check("flags_q", flags_q, m_flags);
`endif
    for (int k = 0; k < bp; k++) begin
      bus.req_valid = '1;
      bus.rsp_ready = ~oh;
      @(negedge clk);
      check("bp_rsp_valid", bus.rsp_valid, oh);
      check("bp_rsp_result", bus.rsp_result, exp_res);
      check("bp_rsp_flags", bus.rsp_flags, exp_flg);
      check("bp_req_ready", bus.req_ready, 0);
    end
    bus.req_valid = '0;
    bus.rsp_ready = oh;
    @(negedge clk);
    check("rsp_done", bus.rsp_valid, 0);
    bus.rsp_ready = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         grants[$];
    logic [35:0] m;
    logic [NREQ-1:0] mask;
    int         win;

    vecs[0]  = '{0, 0, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 4'b0000};
    vecs[1]  = '{0, 0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 32'h8000_0000, 4'b1001};
    vecs[2]  = '{1, 1, 32'h0000_1234, 32'h0000_1234, 1'b0, 32'h0000_0000, 4'b0110};
    vecs[3]  = '{1, 0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0000, 4'b0110};
    vecs[4]  = '{0, 1, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 4'b1000};
    vecs[5]  = '{1, 1, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 4'b0011};
    vecs[6]  = '{0, 2, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'hF000_F000, 4'b1000};
    vecs[7]  = '{1, 3, 32'h0000_000F, 32'h0000_00F0, 1'b0, 32'h0000_00FF, 4'b0000};
    vecs[8]  = '{0, 4, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b1, 32'h0000_0000, 4'b0100};
    vecs[9]  = '{1, 5, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 4'b1000};
    vecs[10] = '{0, 6, 32'h0000_0000, 32'h1234_5678, 1'b0, 32'h1234_5678, 4'b0000};
    vecs[11] = '{1, 7, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0001, 4'b0000};

    bus.req_valid    = '0;
    bus.rsp_ready    = '0;
    bus.req_opcode   = '0;
    bus.req_a        = '0;
    bus.req_b        = '0;
    bus.req_setflags = '0;
    for (int r = 0; r < NREQ; r++) set_req(r, 0, 32'h0, 32'h0, 1'b0);

    do_reset();

    for (int i = 0; i < 12; i++) begin
      set_req(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sf);
      do_txn(NREQ'(1 << vecs[i].id), vecs[i].id, vecs[i].res, vecs[i].flg, vecs[i].sf, (i % 4 == 3) ? 1 : 0);
    end

    // Response backpressure on requester 1 for five cycles
    set_req(1, 0, 32'h0000_0010, 32'h0000_0020, 1'b0);
    set_req(0, 4, 32'h5555_5555, 32'h0000_FFFF, 1'b0);
    do_txn(2'b10, 1, 32'h0000_0030, 4'b0000, 1'b0, 5);

    // Contention from reset: both valid, responses always accepted
    do_reset();
    set_req(0, 0, 32'h0000_0001, 32'h0000_0001, 1'b0);
    set_req(1, 0, 32'h0000_0002, 32'h0000_0002, 1'b0);
    bus.req_valid = '1;
    bus.rsp_ready = '1;
    for (int c = 0; c < 15; c++) begin
      #1;
      check("no_double_grant", $countones(bus.req_ready) <= 1, 1);
      if (bus.req_ready[0]) grants.push_back(0);
      if (bus.req_ready[1]) grants.push_back(1);
      @(negedge clk);
    end
    bus.req_valid = '0;
    check("contention_grant_count", grants.size(), 5);
    for (int g = 0; g < grants.size(); g++) begin
      check("contention_order", grants[g], m_rr);
      m_rr = (m_rr + 1) % NREQ;
    end
    @(negedge clk);
    @(negedge clk);
    bus.rsp_ready = '0;

    // Reset while in RESP discards the transaction and the flag register
    do_reset();
    set_req(0, 0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
    bus.req_valid = 2'b01;
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    check("rst_resp_valid_before", bus.rsp_valid, 2'b01);
`ifdef ALU_ARB_FLAG_REG_EN
    check("rst_flags_q_before", flags_q, 4'b1001);
`endif
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_rsp_valid_after", bus.rsp_valid, 0);
    check("rst_rsp_result_after", bus.rsp_result, 0);
`ifdef ALU_ARB_FLAG_REG_EN
    check("rst_flags_q_after", flags_q, 0);
`endif
    bus.req_valid = '1;
    #1;
    check("rst_rr_restart", bus.req_ready, 2'b01);
    bus.req_valid = '0;
    m_rr = 0;
    m_flags = 4'h0;

    // Randomised traffic against the transaction-level model
    for (int t = 0; t < 40; t++) begin
      for (int r = 0; r < NREQ; r++) begin
        set_req(r, int'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 3) == 0) ? 32'h1 : $urandom,
                1'($urandom_range(0, 1)));
      end
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      win = -1;
      for (int i = 0; i < NREQ; i++) begin
        if (win < 0 && mask[(m_rr + i) % NREQ]) win = (m_rr + i) % NREQ;
      end
      m = ref_alu(r_op[win], r_a[win], r_b[win]);
      do_txn(mask, win, m[35:4], m[3:0], r_sf[win], int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational `alu` instance between up to four requesters (fetch-side address adder, execute stage, debug port) using round-robin arbitration with valid/ready handshakes on both request and response. Each accepted request's operands are registered and executed on the shared ALU. The result and flags are held in a response register until the owning requester accepts them. The block sits between the requesters and the single `alu` instance in the processor datapath.

## Interface
- `N`, 32, datapath width passed to `alu`.
- `NREQ`, 2, number of requesters; legal range 2..4.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester grant/accept; at most one bit set.
- `req_opcode`  in  NREQ×3  per-requester ALU opcode.
- `req_a`, `req_b`  in  NREQ×N  per-requester operands.
- `req_setflags`  in  NREQ  request updates the architectural flag register.
- `rsp_valid`  out  NREQ  one-hot response valid to the owning requester.
- `rsp_ready`  in  NREQ  per-requester response accept.
- `rsp_result`  out  N  shared result bus; meaningful only where `rsp_valid` is set.
- `rsp_flags`  out  4  {N,Z,C,V} of this operation.
- `flags_q`  out  4  architectural flag register {N,Z,C,V}; present only with the `ALU_ARB_FLAG_REG_EN` macro.

## Operation
- FSM states:
  - IDLE: `req_ready` = one-hot grant of the winner among `req_valid`. On `req_valid[w] & req_ready[w]`, capture opcode, operands, setflags and owner id w, then go to EXEC. If no request is valid, stay in IDLE.
  - EXEC: the registered opcode and operands drive `alu`. Register result and {N,Z,C,V} into the response register and go to RESP.
  - RESP: `rsp_valid[owner]`=1 and the response register is held stable. On `rsp_ready[owner]`, go to IDLE. Otherwise stay, indefinitely.
- Round-robin arbitration:
  - Search starts at pointer `rr_q` and proceeds in increasing index, wrapping modulo NREQ.
  - On acceptance, `rr_q` ← (w+1) mod NREQ. Wrap from NREQ-1 to 0.
  - Grant is a combinational function of `req_valid` and `rr_q` only.
- Requester rules:
  - A requester must hold its request fields stable while `req_valid` is high and not yet accepted.
  - A requester may drop `req_valid` before being granted without side effects.
- `rsp_ready` of non-owners is ignored. `rsp_ready[owner]` outside RESP is ignored.
- Only one transaction is in flight at a time. Requests arriving during EXEC/RESP wait with `req_ready`=0.
- Flags: C and V come from `alu` unchanged. N = result[N-1]. Z = (result == 0).

## Timing
- Request accepted at edge t. EXEC occupies cycle t+1. `rsp_valid` is high from t+2.
- Minimum occupancy is 3 cycles per transaction: IDLE, EXEC, RESP with `rsp_ready` already high. The next grant is possible in the cycle after RESP exits.
- Reset values: state=IDLE, `rr_q`=0, `req_ready`=0 during the reset cycle, `rsp_valid`=0, `rsp_result`=0, `rsp_flags`=0, `flags_q`=0.
- Reset mid-operation, in EXEC or RESP: the transaction is discarded, no response is issued, and the flag register is not updated.
- Multiple `req_valid` in the same cycle: only the round-robin winner is accepted. The others keep waiting.

## Configuration
- `ALU_ARB_FLAG_REG_EN` defined:
  - `flags_q` port exists.
  - At the EXEC→RESP edge, if the captured setflags=1, `flags_q` ← the new {N,Z,C,V}. Otherwise `flags_q` holds its value.
- `ALU_ARB_FLAG_REG_EN` undefined:
  - There is no `flags_q` port and no flag register.
  - `req_setflags` is accepted and ignored.
  - Flags are reported only on `rsp_flags`.

## Structure
- Shared package `alu_pkg`:
  - 3-bit opcode typedef with named constants matching the `alu` decode (`ALU_ADD`, `ALU_SUB`, `ALU_AND`, ...).
  - Packed flags struct {n,z,c,v}.
  - FSM state enum.
  - Requester-id width constant `$clog2(4)`.
- One sub-module: the existing `alu`, instantiated once with `#(N)`.
- The arbiter's round-robin grant logic is kept inline; it is not a separate module.

## Test plan
- Single request: requester 0 sends `ALU_ADD` 0x0000_0005 + 0x0000_0003. Required: `rsp_valid[0]` exactly 2 cycles after acceptance, result 0x0000_0008, flags 0000.
- Overflow flags: `ALU_ADD` 0x7FFF_FFFF + 0x0000_0001 with setflags=1. Required: result 0x8000_0000, `rsp_flags` N=1 Z=0 C=0 V=1. With the macro, `flags_q`=4'b1001 from the cycle after EXEC.
- Contention: both requesters valid continuously from reset, with `rsp_ready` held high. Required grants alternate 0,1,0,1, and there is never a double grant.
- Response backpressure: `rsp_ready[1]` held low for 5 cycles. Required: `rsp_valid[1]`, result and flags are stable for all 5 cycles, and `req_ready` stays 0 throughout.
- Zero result with setflags=0: `ALU_SUB` 0x1234 - 0x1234. Required: Z=1 on `rsp_flags`, and `flags_q` unchanged from its prior value.
- Reset in RESP: assert `reset` for one cycle while `rsp_valid[0]`=1. Required: the next cycle has `rsp_valid`=0, state IDLE, `rr_q`=0 and `flags_q`=0.
